// File: rtl/mesh_sched_pkg.sv
// Shared types and default sizing for the mesh job scheduler.
// Imported by the scheduler top and its preload streamer.
package mesh_sched_pkg;

  localparam int DEF_DW      = 8;
  localparam int DEF_ROWS    = 64;
  localparam int DEF_COLS    = 64;
  localparam int DEF_ROW_W   = 6;
  localparam int DEF_COL_W   = 6;
  localparam int DEF_WADDR_W = 16;

  localparam int N_WEIGHTS  = DEF_ROWS * DEF_COLS;
  localparam int PRELOAD_AW = DEF_ROW_W + DEF_COL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_HOLD
  } sched_state_t;

endpackage

// File: rtl/mesh_preload_streamer.sv
// Streams a weight tile from SRAM into the mesh preload port.
// Reads run one cycle ahead of the matching preload write.
module mesh_preload_streamer
  import mesh_sched_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int WADDR_W = DEF_WADDR_W,
  parameter int N_W     = N_WEIGHTS,
  parameter int AW      = PRELOAD_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WADDR_W-1:0] wbase,
  output logic               rd_en,
  output logic [WADDR_W-1:0] rd_addr,
  input  logic [DW-1:0]      rd_data,
  output logic               pv,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pdata,
  output logic               done
);

  logic [AW-1:0] k;

  assign done  = rd_en && (k == AW'(N_W - 1));
  assign pdata = pv ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      k       <= '0;
      pv      <= 1'b0;
      paddr   <= '0;
    end else begin
      pv    <= rd_en;
      paddr <= rd_en ? k : '0;
      if (go) begin
        rd_en   <= 1'b1;
        rd_addr <= wbase;
        k       <= '0;
      end else if (rd_en) begin
        if (done) begin
          rd_en <= 1'b0;
          k     <= '0;
        end else begin
          // address wraps at the top of SRAM
          k       <= k + 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mesh_job_scheduler.sv
// Sequences one matrix-vector job: preload, start, wait, return.
// Holds the FSM, the compute wait counter and the result register.
module mesh_job_scheduler
  import mesh_sched_pkg::*;
#(
  parameter int DW             = 8,
  parameter int ROWS           = 64,
  parameter int COLS           = 64,
  parameter int ROW_W          = 6,
  parameter int COL_W          = 6,
  parameter int ACC_W          = 16,
  parameter int COMPUTE_CYCLES = 130,
  parameter int CYCLE_W        = 8,
  parameter int WADDR_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [WADDR_W-1:0]     job_wbase,
  input  logic                   job_reuse,
  output logic                   wmem_rd_en,
  output logic [WADDR_W-1:0]     wmem_rd_addr,
  input  logic [DW-1:0]          wmem_rd_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   start,
  input  logic [ROWS*ACC_W-1:0]  mesh_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ROWS*ACC_W-1:0]  res_data,
  output logic                   busy,
  output logic [15:0]            job_count
);

  localparam int AW = ROW_W + COL_W;
  localparam logic [CYCLE_W-1:0] LAST =
    CYCLE_W'(COMPUTE_CYCLES - 1);

  sched_state_t     state;
  logic             weights_loaded;
  logic [CYCLE_W-1:0] cnt;
  logic             reuse_ok;
  logic             go;
  logic             load_done;

  assign reuse_ok  = job_reuse && weights_loaded;
  assign go        = (state == S_IDLE) && job_valid && !reuse_ok;
  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_HOLD);

  mesh_preload_streamer #(
    .DW      (DW),
    .WADDR_W (WADDR_W),
    .N_W     (ROWS * COLS),
    .AW      (AW)
  ) u_streamer (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .wbase   (job_wbase),
    .rd_en   (wmem_rd_en),
    .rd_addr (wmem_rd_addr),
    .rd_data (wmem_rd_data),
    .pv      (preload_valid),
    .paddr   (preload_addr),
    .pdata   (preload_data),
    .done    (load_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      weights_loaded <= 1'b0;
      job_count      <= '0;
      start          <= 1'b0;
      cnt            <= '0;
      res_data       <= '0;
    end else begin
      start <= 1'b0;
      if (preload_valid && (preload_addr == '1))
        weights_loaded <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (job_valid) begin
            if (reuse_ok) begin
              state <= S_START;
              start <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (load_done) begin
            state <= S_START;
            start <= 1'b1;
          end
        end
        S_START: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (cnt == LAST) begin
            res_data <= mesh_result;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            job_count <= job_count + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Scoreboard bench for mesh_job_scheduler on a 4x4 mesh.
// Driver queues expected results; a monitor checks HOLD.
module tb_mesh_job_scheduler;

  localparam int DW      = 8;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int ROW_W   = 2;
  localparam int COL_W   = 2;
  localparam int ACC_W   = 16;
  localparam int CC      = 10;
  localparam int CYCLE_W = 8;
  localparam int WADDR_W = 16;
  localparam int N       = ROWS * COLS;

  logic                   clk;
  logic                   rst;
  logic                   job_valid;
  logic                   job_ready;
  logic [WADDR_W-1:0]     job_wbase;
  logic                   job_reuse;
  logic                   wmem_rd_en;
  logic [WADDR_W-1:0]     wmem_rd_addr;
  logic [DW-1:0]          wmem_rd_data;
  logic                   preload_valid;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0]          preload_data;
  logic                   start;
  logic [ROWS*ACC_W-1:0]  mesh_result;
  logic                   res_valid;
  logic                   res_ready;
  logic [ROWS*ACC_W-1:0]  res_data;
  logic                   busy;
  logic [15:0]            job_count;

  mesh_job_scheduler #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS),
    .ROW_W(ROW_W), .COL_W(COL_W), .ACC_W(ACC_W),
    .COMPUTE_CYCLES(CC), .CYCLE_W(CYCLE_W),
    .WADDR_W(WADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_wbase(job_wbase), .job_reuse(job_reuse),
    .wmem_rd_en(wmem_rd_en),
    .wmem_rd_addr(wmem_rd_addr),
    .wmem_rd_data(wmem_rd_data),
    .preload_valid(preload_valid),
    .preload_addr(preload_addr),
    .preload_data(preload_data),
    .start(start),
    .mesh_result(mesh_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data),
    .busy(busy), .job_count(job_count)
  );

  typedef struct {
    logic [63:0] data;
    int          first;
    int          cnt;
    int          stall;
  } exp_t;

  exp_t sb[$];
  int   rd_q[$];
  int   pw_q[$];
  int   st_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_jobs = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mr(input int c);
    logic [15:0] v;
    v = c[15:0];
    return {v ^ 16'hA5A5, v + 16'd3, ~v, v};
  endfunction

  assign mesh_result = mr(cyc);

  always @(posedge clk)
    wmem_rd_data <= wmem_rd_en ? wmem_rd_addr[7:0] : 8'h00;

  always @(negedge clk) begin
    if (wmem_rd_en === 1'b1)
      rd_q.push_back(int'(wmem_rd_addr));
    if (preload_valid === 1'b1)
      pw_q.push_back(int'({preload_addr, preload_data}));
    if (start === 1'b1)
      st_q.push_back(cyc);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // result monitor: pops expectation on first HOLD cycle
  initial begin
    exp_t e;
    bit seen;
    logic [63:0] held;
    int stall_left;
    seen = 0;
    stall_left = 0;
    held = '0;
    e = '{data: '0, first: 0, cnt: 0, stall: 0};
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0h",
                     res_data);
          end else begin
            e = sb.pop_front();
            chk("res_latency", 64'(cyc), 64'(e.first));
            chk("res_data", res_data, e.data);
          end
          held = res_data;
          stall_left = e.stall;
        end
        chk("hold_stable", res_data, held);
        chk("hold_job_ready", 64'(job_ready), 64'(0));
        chk("hold_count", 64'(job_count), 64'(e.cnt));
        if (stall_left > 0) begin
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
        end
      end else if (seen) begin
        seen = 0;
        chk("count_after", 64'(job_count),
            64'(e.cnt + 1));
      end
    end
  end

  task automatic run_job(input logic [15:0] wb,
                         input logic reuse,
                         input bit full,
                         input int stall);
    int acc;
    int t;
    int n_exp;
    logic [15:0] a;
    rd_q.delete();
    pw_q.delete();
    st_q.delete();
    @(negedge clk);
    chk("idle_ready", 64'(job_ready), 64'(1));
    job_wbase = wb;
    job_reuse = reuse;
    job_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    job_valid = 1'b0;
    job_reuse = 1'b0;
    chk("accept_busy", 64'(busy), 64'(1));
    sb.push_back('{
      data:  mr(full ? acc + N + CC : acc + CC),
      first: full ? acc + N + CC + 1 : acc + CC + 1,
      cnt:   exp_jobs,
      stall: stall});
    exp_jobs++;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (job_ready !== 1'b1 && t < 300);
    chk("job_done", 64'(job_ready), 64'(1));
    n_exp = full ? N : 0;
    chk("rd_count", 64'(rd_q.size()), 64'(n_exp));
    chk("pw_count", 64'(pw_q.size()), 64'(n_exp));
    foreach (rd_q[i]) begin
      a = wb + 16'(i);
      chk("rd_addr", 64'(rd_q[i]), 64'(a));
    end
    foreach (pw_q[i]) begin
      a = wb + 16'(i);
      chk("preload", 64'(pw_q[i]),
          64'((i << 8) | int'(a[7:0])));
    end
    chk("start_count", 64'(st_q.size()), 64'(1));
    if (st_q.size() > 0)
      chk("start_cyc", 64'(st_q[0]),
          64'(full ? acc + N : acc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    job_valid = 1'b0;
    job_reuse = 1'b0;
    job_wbase = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", 64'(job_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(job_count), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_rd_en", 64'(wmem_rd_en), 64'(0));
    chk("rst_pv", 64'(preload_valid), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_res_data", res_data, 64'(0));
    rst = 1'b0;

    run_job(16'h0010, 1'b1, 1'b1, 0);
    run_job(16'h0300, 1'b1, 1'b0, 0);
    run_job(16'hFFFE, 1'b0, 1'b1, 5);
    run_job(16'h0000, 1'b1, 1'b0, 0);

    // abort a load mid-stream
    @(negedge clk);
    job_wbase = 16'h0100;
    job_reuse = 1'b0;
    job_valid = 1'b1;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(preload_valid === 1'b1 &&
                 preload_addr == 4'd7) && t < 50);
    chk("reach_write7", 64'(preload_addr), 64'(7));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_pv", 64'(preload_valid), 64'(0));
    chk("abort_rd_en", 64'(wmem_rd_en), 64'(0));
    chk("abort_ready", 64'(job_ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_start", 64'(start), 64'(0));
    chk("abort_count", 64'(job_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_jobs = 0;

    run_job(16'h0040, 1'b1, 1'b1, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
